rptr_empty_fwft: RTL and testbench



---
 rtl/rptr_empty_fwft_if.sv | 29 ++
 rtl/rptr_empty_fwft.sv | 93 +++++++++
 tb/tb_rptr_empty_fwft.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rptr_empty_fwft_if.sv
// Read-side bundle between the async FIFO memory/synchronizer and the
// read-pointer/show-ahead block.
interface rptr_empty_fwft_if #(
    parameter int unsigned ADDRSIZE = 4,
    parameter int unsigned DATASIZE = 8
);
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [DATASIZE-1:0] rdata_mem;
    logic                rready;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                arempty;
    logic [ADDRSIZE:0]   rlevel;
    logic                rvalid;
    logic [DATASIZE-1:0] rdata;

    // Environment side: synchronized write pointer, memory data, consumer ready.
    modport master (
        output rq2_wptr, rdata_mem, rready,
        input  raddr, rptr, rempty, arempty, rlevel, rvalid, rdata
    );

    // Block side.
    modport slave (
        input  rq2_wptr, rdata_mem, rready,
        output raddr, rptr, rempty, arempty, rlevel, rvalid, rdata
    );
endinterface

// File: rtl/rptr_empty_fwft.sv
// Async FIFO read side: binary/Gray read pointer, registered empty/almost-empty,
// occupancy, and a first-word-fall-through output register.
module rptr_empty_fwft #(
    parameter int unsigned ADDRSIZE = 4,
    parameter int unsigned DATASIZE = 8
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    rptr_empty_fwft_if.slave     rd_if
);
    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0]       rbin_q, rbin_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [PW-1:0]       rlevel_q, rlevel_d;
    logic                rempty_q, rempty_d;
    logic                arempty_q, arempty_d;
    logic                rvalid_q, rvalid_d;
    logic [DATASIZE-1:0] rdata_q, rdata_d;

    logic                pop_c;
    logic [PW-1:0]       rbinp1_c;
    logic [PW-1:0]       rgraynextp1_c;
    logic [PW-1:0]       wbin_c;

    // Gray-to-binary of the synchronized write pointer: bit i is the XOR of bits [PW-1:i].
    always_comb begin
        wbin_c = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wbin_c[i] = ^(rd_if.rq2_wptr >> i);
        end
    end

    // Pop decision, pointer advance, flags and output-stage next state.
    always_comb begin
        pop_c         = 1'b0;
        rbin_d        = rbin_q;
        rptr_d        = rptr_q;
        rbinp1_c      = '0;
        rgraynextp1_c = '0;
        rempty_d      = rempty_q;
        arempty_d     = arempty_q;
        rlevel_d      = rlevel_q;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;

        pop_c         = ~rempty_q & (~rvalid_q | rd_if.rready);
        rbin_d        = rbin_q + PW'(pop_c);
        rptr_d        = (rbin_d >> 1) ^ rbin_d;
        rbinp1_c      = rbin_d + PW'(1);
        rgraynextp1_c = (rbinp1_c >> 1) ^ rbinp1_c;

        // Full-width Gray compare keeps a wrapped (full) pointer distinct from empty.
        rempty_d      = (rptr_d == rd_if.rq2_wptr);
        arempty_d     = (rgraynextp1_c == rd_if.rq2_wptr);
        rlevel_d      = wbin_c - rbin_d;

        if (pop_c) begin
            rdata_d  = rd_if.rdata_mem;
            rvalid_d = 1'b1;
        end else if (rvalid_q && rd_if.rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rempty_q  <= 1'b1;
            arempty_q <= 1'b0;
            rlevel_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rempty_q  <= rempty_d;
            arempty_q <= arempty_d;
            rlevel_q  <= rlevel_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rd_if.raddr   = rbin_q[ADDRSIZE-1:0];
    assign rd_if.rptr    = rptr_q;
    assign rd_if.rempty  = rempty_q;
    assign rd_if.arempty = arempty_q;
    assign rd_if.rlevel  = rlevel_q;
    assign rd_if.rvalid  = rvalid_q;
    assign rd_if.rdata   = rdata_q;
endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Bench for rptr_empty_fwft: directed phases plus random traffic, checked every
// cycle against a count/queue based reference of the read side.
module tb_rptr_empty_fwft;
    localparam int unsigned ADDRSIZE = 4;
    localparam int unsigned DATASIZE = 8;
    localparam int DEPTH = 16;

    logic rclk;
    logic rrst_n;

    rptr_empty_fwft_if #(.ADDRSIZE(ADDRSIZE), .DATASIZE(DATASIZE)) bus ();

    rptr_empty_fwft #(.ADDRSIZE(ADDRSIZE), .DATASIZE(DATASIZE)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rd_if  (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // FIFO memory as seen by the read side: combinational read at raddr.
    logic [7:0] mem [DEPTH];
    assign bus.rdata_mem = mem[bus.raddr];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: unbounded write/pop counts and the queue of unread data.
    int         wr_cnt;
    int         rd_cnt;
    logic [7:0] exp_q [$];
    bit         m_empty, m_arempty, m_valid;
    int         m_level;
    logic [7:0] m_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [4:0] gray5(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    // One read-clock edge of the reference, from the inputs held across the edge.
    task automatic model_edge();
        bit pop;
        if (!rrst_n) begin
            rd_cnt    = 0;
            m_empty   = 1'b1;
            m_arempty = 1'b0;
            m_level   = 0;
            m_valid   = 1'b0;
            m_data    = 8'h00;
        end else begin
            pop = !m_empty && (!m_valid || bus.rready);
            if (pop) begin
                m_data  = exp_q.pop_front();
                m_valid = 1'b1;
                rd_cnt++;
            end else if (m_valid && bus.rready) begin
                m_valid = 1'b0;
            end
            m_empty   = (wr_cnt == rd_cnt);
            m_arempty = (wr_cnt == rd_cnt + 1);
            m_level   = wr_cnt - rd_cnt;
        end
    endtask

    task automatic step();
        @(posedge rclk);
        model_edge();
        #1;
        chk("rempty",  32'(bus.rempty),  32'(m_empty));
        chk("arempty", 32'(bus.arempty), 32'(m_arempty));
        chk("rlevel",  32'(bus.rlevel),  32'(m_level));
        chk("rvalid",  32'(bus.rvalid),  32'(m_valid));
        chk("rdata",   32'(bus.rdata),   32'(m_data));
        chk("rptr",    32'(bus.rptr),    32'(gray5(rd_cnt)));
        chk("raddr",   32'(bus.raddr),   32'(rd_cnt % DEPTH));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Write side: store one entry if the memory has room, then publish the pointer.
    task automatic do_write(input logic [7:0] d);
        if (wr_cnt - rd_cnt < DEPTH) begin
            mem[wr_cnt % DEPTH] = d;
            exp_q.push_back(d);
            wr_cnt++;
            bus.rq2_wptr = gray5(wr_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        wr_cnt = 0;
        rd_cnt = 0;
        m_empty = 1'b1; m_arempty = 1'b0; m_valid = 1'b0; m_level = 0; m_data = 8'h00;
        rrst_n = 1'b0;
        bus.rready = 1'b0;
        bus.rq2_wptr = '0;

        // Reset with two entries already written (Gray 5'b00011), then release.
        do_write(8'h11);
        do_write(8'h22);
        steps(2);
        rrst_n = 1'b1;
        steps(3);
        bus.rready = 1'b1;
        steps(4);

        // Single entry with the consumer stalled.
        bus.rready = 1'b0;
        do_write(8'hA5);
        steps(5);
        bus.rready = 1'b1;
        steps(2);

        // Streaming: 16 entries back-to-back.
        for (int i = 0; i < 16; i++) do_write(8'(i));
        steps(20);

        // Backpressure: three entries, consumer stalled, then released.
        bus.rready = 1'b0;
        for (int i = 0; i < 3; i++) do_write(8'(8'h30 + i));
        steps(7);
        bus.rready = 1'b1;
        steps(5);

        // Wrap: 40 entries in bursts of 16, 16, 8.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < ((b == 2) ? 8 : 16); i++) do_write(8'(8'h40 + b * 16 + i));
            steps(20);
        end

        // Random traffic: one write at most per cycle, random consumer ready.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(1, 0) == 1) do_write(8'($urandom));
            bus.rready = ($urandom_range(3, 0) != 0);
            step();
        end
        bus.rready = 1'b1;
        steps(20);

        // Mid-stream reset with one entry in the output stage and seven in memory.
        bus.rready = 1'b0;
        for (int i = 0; i < 8; i++) do_write(8'(8'hC0 + i));
        steps(4);
        rrst_n = 1'b0;
        wr_cnt = 0;
        exp_q.delete();
        bus.rq2_wptr = '0;
        step();
        rrst_n = 1'b1;
        steps(3);
        do_write(8'h5A);
        bus.rready = 1'b1;
        steps(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
